// File: rtl/uart_tx.sv
// UART transmitter: pops one word per frame from an upstream FIFO and serialises it LSB first.
// Optional even-parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int unsigned TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned BW = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   tick_q;
  logic [BW-1:0]   bit_q;
  logic [DBIT-1:0] shreg_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
  logic            arm_q;
`ifdef UART_TX_PARITY_EN
  logic            par_q;
`endif

  // arm_q keeps the pop strobe quiet until the first edge after reset release
  assign fifo_rd      = arm_q && (state_q == IDLE) && !fifo_empty;
  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      arm_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      arm_q  <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (fifo_rd) begin
            shreg_q <= fifo_data;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^fifo_data;
`endif
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_q == TW'(15)) begin
              tick_q  <= '0;
              tx_q    <= shreg_q[0];
              state_q <= DATA;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_q == TW'(15)) begin
              tick_q  <= '0;
              shreg_q <= {1'b0, shreg_q[DBIT-1:1]};
              if (bit_q == BW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                tx_q    <= par_q;
                state_q <= PARITY;
`else
                tx_q    <= 1'b1;
                state_q <= STOP;
`endif
              end else begin
                bit_q <= bit_q + BW'(1);
                tx_q  <= shreg_q[1];
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (tick_q == TW'(15)) begin
              tick_q  <= '0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (tick_q == TW'(SB_TICK - 1)) begin
              tick_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: FIFO model feeds words, a line monitor decodes frames against a scoreboard.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FT = 16 * (10 + PAR);

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_tick;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd, tx, tx_busy, tx_done_tick;
  logic       f2_empty;
  logic [7:0] f2_data;
  logic       f2_rd, tx2, busy2, done2;

  uart_tx #(.DBIT(8), .SB_TICK(16)) u_dut (
    .clk(clk), .reset(rst_n), .s_tick(s_tick), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  uart_tx #(.DBIT(8), .SB_TICK(32)) u_dut32 (
    .clk(clk), .reset(rst_n), .s_tick(s_tick), .fifo_empty(f2_empty),
    .fifo_data(f2_data), .fifo_rd(f2_rd), .tx(tx2), .tx_busy(busy2),
    .tx_done_tick(done2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0, phase = 0;
  int pop_cnt = 0, pop_cyc = 0, done_cnt = 0, done_cyc = 0, b2b_cnt = 0, frames = 0;
  logic rd_pend = 1'b0;
  logic [7:0] fifo_q[$];
  vec_t exp_q[$];
  vec_t tbl[9];

  logic       mon_on = 1'b0;
  int         mon_n = 0;
  logic [9:0] rx_seq;
  logic       rx_par;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // FIFO model pops on the edge after a strobe; tick generator runs at 1/4 clk
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rd_pend) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_cnt++;
      pop_cyc = cyc;
      rd_pend = 1'b0;
      fifo_empty = (fifo_q.size() == 0);
      if (fifo_q.size() > 0) fifo_data = fifo_q[0];
    end
    phase = (phase == 3) ? 0 : phase + 1;
    s_tick = (phase == 3);
  end

  // Line monitor: samples each bit at its 8th tick and checks the frame when the stop bit ends
  always @(negedge clk) begin
    rd_pend = fifo_rd;
    if (fifo_rd) begin
      check("pop_nonempty", 32'(fifo_q.size() > 0), 32'd1);
      if (tx_done_tick) b2b_cnt++;
    end
    if (tx_done_tick) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!rst_n) begin
      mon_on = 1'b0;
    end else begin
      if (!mon_on && tx == 1'b0) begin
        mon_on = 1'b1;
        mon_n  = 0;
        frames++;
      end
      if (mon_on) begin
        if (mon_n == FT) begin
          check("done_at_frame_end", 32'(tx_done_tick), 32'd1);
          if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
          end else begin
            vec_t e;
            e = exp_q.pop_front();
            check($sformatf("frame_%02h", e.data), 32'(rx_seq), 32'(e.seq));
`ifdef UART_TX_PARITY_EN
            check($sformatf("parity_%02h", e.data), 32'(rx_par), 32'(e.par));
`endif
          end
          mon_on = 1'b0;
        end else begin
          if (tx_done_tick) begin
            errors++;
            $display("FAIL done_early: pulse at tick %0d of %0d", mon_n, FT);
          end
          if (s_tick) begin
            if (mon_n % 16 == 8) begin
              int b;
              b = mon_n / 16;
              if (b == 0) rx_seq[9] = tx;
              else if (b <= 8) rx_seq[9-b] = tx;
              else if (PAR == 1 && b == 9) rx_par = tx;
              else rx_seq[0] = tx;
            end
            mon_n++;
          end
        end
      end
    end
  end

  task automatic push_vec(input vec_t v);
    fifo_q.push_back(v.data);
    exp_q.push_back(v);
    fifo_data  = fifo_q[0];
    fifo_empty = 1'b0;
  endtask

  task automatic align_tick();
    do begin
      @(posedge clk);
      #2;
    end while (!s_tick);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #2;
    check("wait_done_count", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    int p0, d0, b0, n, lowstop, t;
    tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
    tbl[1] = '{8'h00, 10'b0000000001, 1'b0};
    tbl[2] = '{8'hFF, 10'b0111111111, 1'b0};
    tbl[3] = '{8'h3C, 10'b0001111001, 1'b0};
    tbl[4] = '{8'h55, 10'b0101010101, 1'b0};
    tbl[5] = '{8'h07, 10'b0111000001, 1'b1};
    tbl[6] = '{8'h03, 10'b0110000001, 1'b0};
    tbl[7] = '{8'h81, 10'b0100000011, 1'b0};
    tbl[8] = '{8'hC4, 10'b0001000111, 1'b1};

    rst_n = 1'b0; s_tick = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00;
    f2_empty = 1'b1; f2_data = 8'h81;
    repeat (3) @(posedge clk);
    #2;
    fifo_empty = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done_tick), 32'd0);
    check("rst_tx32", 32'(tx2), 32'd1);
    fifo_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with empty FIFO for 100 bit-ticks
    repeat (400) @(posedge clk);
    #2;
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_pops", 32'(pop_cnt), 32'd0);
    check("idle_busy", 32'(tx_busy), 32'd0);
    check("idle_frames", 32'(frames), 32'd0);

    // Single frames from the table, tick-aligned so latency is exactly 4 clk per tick
    for (int i = 0; i < 9; i++) begin
      d0 = done_cnt;
      align_tick();
      push_vec(tbl[i]);
      wait_done(d0 + 1);
      check($sformatf("latency_%02h", tbl[i].data), 32'(done_cyc - pop_cyc), 32'(4 * FT));
      check($sformatf("pops_%02h", tbl[i].data), 32'(pop_cnt), 32'(i + 1));
      repeat (8) @(posedge clk);
    end

    // Three queued words go out back to back
    p0 = pop_cnt; d0 = done_cnt; b0 = b2b_cnt;
    @(posedge clk); #2;
    push_vec(tbl[1]); push_vec(tbl[2]); push_vec(tbl[3]);
    wait_done(d0 + 3);
    check("b2b_pops", 32'(pop_cnt - p0), 32'd3);
    check("b2b_no_gap", 32'(b2b_cnt - b0), 32'd2);
    repeat (8) @(posedge clk);

    // Reset in the middle of data bit 3 of 8'h55
    p0 = pop_cnt;
    align_tick();
    push_vec(tbl[4]);
    t = 0;
    while (pop_cnt == p0 && t < 20) begin @(posedge clk); t++; end
    check("abort_popped", 32'(pop_cnt - p0), 32'd1);
    n = 0;
    while (n < 72) begin
      @(negedge clk);
      if (s_tick) n++;
    end
    @(posedge clk); #2;
    push_vec(tbl[0]);
    check("abort_bit3_low", 32'(tx), 32'd0);
    d0 = done_cnt; p0 = pop_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_fifo_rd", 32'(fifo_rd), 32'd0);
    void'(exp_q.pop_front());
    repeat (5) @(posedge clk);
    #2;
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_no_pop", 32'(pop_cnt), 32'(p0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(d0 + 1);
    check("after_abort_pop", 32'(pop_cnt - p0), 32'd1);
    repeat (8) @(posedge clk);

    // SB_TICK=32 instance: stop period of 32 ticks before the done pulse
    align_tick();
    f2_empty = 1'b0;
    #1;
    check("sb32_rd", 32'(f2_rd), 32'd1);
    @(posedge clk); #2;
    f2_empty = 1'b1;
    n = 0; lowstop = 0; t = 0;
    while (t < 3000) begin
      @(negedge clk);
      t++;
      if (done2) break;
      if (s_tick) begin
        if (n >= 16 * (9 + PAR) && tx2 != 1'b1) lowstop++;
        n++;
      end
    end
    check("sb32_done_seen", 32'(done2), 32'd1);
    check("sb32_frame_ticks", 32'(n), 32'(16 * (9 + PAR) + 32));
    check("sb32_stop_high", 32'(lowstop), 32'd0);
    @(negedge clk);
    check("sb32_done_one_cycle", 32'(done2), 32'd0);

    check("total_frames", 32'(done_cnt), 32'd13);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
